stepper_phase_sequencer: RTL

//  Downstream consumer of the clock divider's clk_out: turns each rising edge of the divided

---
 rtl/stepper_phase_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/stepper_phase_sequencer.sv
// stepper_phase_sequencer
//   Turns each rising edge of the divided step clock into one motor step and
//   drives four coil lines from an 8-entry half-step table. A commanded move of
//   move_len steps runs in direction dir, in full- or half-step mode. The block
//   reports busy/done and keeps a wrapping signed position count.
//
//   Ports
//     clk        system clock (the only clock)
//     rst        synchronous reset, active low
//     step_clk   divided step clock, sampled as data
//     en         run enable; dropping it aborts the current move
//     start      one-cycle move request, honoured only in IDLE
//     dir        1 = forward (index up), 0 = reverse; latched at start
//     half_step  1 = index step 1, 0 = index step 2; latched at start
//     move_len   step count of the move; latched at start
//     coils      coil drive {A,B,C,D}
//     busy       high while a move is running
//     done       one-cycle pulse when a move completes
//     pos        signed position, +1/-1 per executed step, wraps
//
//   Build option
//     COIL_IDLE_OFF_EN : coils are de-energised (4'b0000) whenever no move is
//                        running. The table index is kept, so the next move
//                        resumes from the stored pattern. Without it the last
//                        pattern is held for holding torque.
module stepper_phase_sequencer #(
    parameter int LEN_W = 16,
    parameter int POS_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_clk,
    input  logic             en,
    input  logic             start,
    input  logic             dir,
    input  logic             half_step,
    input  logic [LEN_W-1:0] move_len,
    output logic [3:0]       coils,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] pos
);

`ifdef COIL_IDLE_OFF_EN
    localparam logic HOLD_OFF = 1'b1;
`else
    localparam logic HOLD_OFF = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    // step_pipe[0] = first sync flop, [1] = second sync flop, [2] = previous
    logic [2:0]       step_pipe;
    logic             tick;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;
    logic [2:0]       step_sz;
    logic [LEN_W-1:0] rem;
    logic             dir_q;
    logic             half_q;

    function automatic logic [3:0] coil_pattern(input logic [2:0] i);
        case (i)
            3'd0:    coil_pattern = 4'b1000;
            3'd1:    coil_pattern = 4'b1100;
            3'd2:    coil_pattern = 4'b0100;
            3'd3:    coil_pattern = 4'b0110;
            3'd4:    coil_pattern = 4'b0010;
            3'd5:    coil_pattern = 4'b0011;
            3'd6:    coil_pattern = 4'b0001;
            default: coil_pattern = 4'b1001;
        endcase
    endfunction

    assign tick    = step_pipe[1] & ~step_pipe[2];
    // Full step moves by 2 so idx parity (wave vs two-phase drive) is kept.
    assign step_sz = half_q ? 3'd1 : 3'd2;
    assign idx_nxt = dir_q ? idx + step_sz : idx - step_sz;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            step_pipe <= '0;
            idx       <= '0;
            rem       <= '0;
            dir_q     <= 1'b0;
            half_q    <= 1'b0;
            coils     <= 4'b0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            pos       <= '0;
        end else begin
            step_pipe <= {step_pipe[1:0], step_clk};
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && en) begin
                        if (move_len != '0) begin
                            state  <= RUN;
                            busy   <= 1'b1;
                            dir_q  <= dir;
                            half_q <= half_step;
                            rem    <= move_len;
                            coils  <= coil_pattern(idx);
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Abort has priority over a coincident tick: no step, no done.
                    if (!en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        rem   <= '0;
                        if (HOLD_OFF) coils <= 4'b0000;
                    end else if (tick) begin
                        idx   <= idx_nxt;
                        coils <= coil_pattern(idx_nxt);
                        pos   <= dir_q ? pos + POS_W'(1) : pos - POS_W'(1);
                        rem   <= rem - LEN_W'(1);
                        if (rem == LEN_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            if (HOLD_OFF) coils <= 4'b0000;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
